cu_multicycle: RTL and testbench

Parameterised multi-cycle control unit for the 32-bit Mini SRC datapath; generalises the fixed fetch/add sequencer to the full 28-opcode instruction set. Decodes IR[31:27], steps a Moore state machine through fetch, execute and write-back, and drives one-hot bus-driver selects, register enables, the register-select lines (Gra/Grb/Grc/Rin/Rout/BAout), the ALU opcode and the RAM strobes. Adds a memory-ready handshake, multi-cycle mul/div hold, conditional branch via CON_FF, and HALT/Stop handling.

---
 rtl/cu_multicycle.sv | 274 +++++++++++++++++++++++++++
 tb/tb_cu_multicycle.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cu_multicycle.sv
// cu_multicycle: Moore control sequencer for the 32-bit Mini SRC datapath.
// Steps fetch (T0..T2), decode (T2D) and up to five execute states (T3..T7)
// for the 28-opcode instruction set, with memory-ready waits, a held
// multi-cycle mul/div step, conditional branch and HALT/Stop handling.
// Optional feature macro: CU_ILLEGAL_TRAP_EN -- when defined, opcodes
// 11100..11111 halt the machine and raise `illegal` until Reset.
module cu_multicycle #(
  parameter int MULDIV_CYCLES = 1,
  parameter int ALU_OPW       = 5
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [31:0]        ir,
  input  logic               CONFFOut,
  input  logic               mem_ready,
  input  logic               Stop,
  output logic [7:0]         bus_sel,
  output logic [9:0]         enable,
  output logic               Gra,
  output logic               Grb,
  output logic               Grc,
  output logic               Rin,
  output logic               Rout,
  output logic               BAout,
  output logic               r15_force,
  output logic               MD_Read,
  output logic               ReadRAM,
  output logic               WriteRAM,
  output logic               IncPC,
  output logic [ALU_OPW-1:0] alu_op,
  output logic               Run,
  output logic               illegal
);

  // bus_sel bit positions
  localparam int BS_PCOUT = 0, BS_MDROUT = 1, BS_ZHIGH = 2, BS_ZLOW = 3;
  localparam int BS_HIOUT = 4, BS_LOOUT = 5, BS_INPORT = 6, BS_COUT = 7;
  // enable bit positions
  localparam int EN_PCIN = 0, EN_IRIN = 1, EN_MARIN = 2, EN_MDRIN = 3, EN_YIN = 4;
  localparam int EN_ZIN = 5, EN_HIIN = 6, EN_LOIN = 7, EN_OUTPIN = 8, EN_CONIN = 9;

  localparam logic [3:0]         MD_LAST = 4'(MULDIV_CYCLES - 1);
  localparam logic [ALU_OPW-1:0] OP_ADD  = ALU_OPW'(5'b00011);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T1W, S_T2, S_T2D,
    S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // Instruction classes sharing one execute-state sequence
  typedef enum logic [3:0] {
    K_ALU, K_IMM, K_MULDIV, K_UNARY, K_LD, K_LDI, K_ST, K_BR,
    K_JR, K_JAL, K_IN, K_OUT, K_MFHI, K_MFLO, K_NOP, K_HALT
  } kind_t;

  function automatic kind_t decode(input logic [4:0] op);
    case (op)
      5'd0:  decode = K_LD;
      5'd1:  decode = K_LDI;
      5'd2:  decode = K_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11:
             decode = K_ALU;
      5'd12, 5'd13, 5'd14: decode = K_IMM;
      5'd15, 5'd16:        decode = K_MULDIV;
      5'd17, 5'd18:        decode = K_UNARY;
      5'd19: decode = K_BR;
      5'd20: decode = K_JR;
      5'd21: decode = K_JAL;
      5'd22: decode = K_IN;
      5'd23: decode = K_OUT;
      5'd24: decode = K_MFHI;
      5'd25: decode = K_MFLO;
      5'd27: decode = K_HALT;
      default: decode = K_NOP;  // nop and the undefined opcodes
    endcase
  endfunction

  state_t      state_q, state_d, to_t0;
  logic [4:0]  op_q;
  logic [3:0]  md_cnt_q;
  kind_t       kind, ir_kind;
  logic        md_done, trap_hit;
  logic        ir_unused;

  assign kind      = decode(op_q);
  assign ir_kind   = decode(ir[31:27]);
  assign md_done   = (md_cnt_q == MD_LAST);
  assign ir_unused = ^ir[26:0];

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign trap_hit = (ir[31:27] >= 5'd28);
  assign illegal  = illegal_q;

  // Sticky undefined-opcode flag, cleared only by Reset
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)                             illegal_q <= 1'b0;
    else if (state_q == S_T2D && trap_hit)  illegal_q <= 1'b1;
  end
`else
  assign trap_hit = 1'b0;
  assign illegal  = 1'b0;
`endif

  // State register, latched opcode and mul/div hold counter
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_RESET;
      op_q     <= 5'd0;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      if (state_q == S_T2D) op_q <= ir[31:27];
      md_cnt_q <= (state_q == S_T4 && state_d == S_T4) ? md_cnt_q + 4'd1 : 4'd0;
    end
  end

  // Next-state logic; every return to T0 is an instruction boundary where Stop wins
  always_comb begin
    state_d = state_q;
    to_t0   = Stop ? S_HALT : S_T0;
    case (state_q)
      S_RESET: state_d = to_t0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = mem_ready ? S_T2 : S_T1W;
      S_T1W:   state_d = mem_ready ? S_T2 : S_T1W;
      S_T2:    state_d = S_T2D;
      S_T2D: begin
        if (ir_kind == K_HALT || trap_hit) state_d = S_HALT;
        else if (ir_kind == K_NOP)         state_d = to_t0;
        else                               state_d = S_T3;
      end
      S_T3: begin
        case (kind)
          K_JR, K_IN, K_OUT, K_MFHI, K_MFLO: state_d = to_t0;
          default:                           state_d = S_T4;
        endcase
      end
      S_T4: begin
        case (kind)
          K_UNARY, K_JAL: state_d = to_t0;
          K_MULDIV:       state_d = md_done ? S_T5 : S_T4;
          default:        state_d = S_T5;
        endcase
      end
      S_T5: begin
        case (kind)
          K_ALU, K_IMM, K_LDI: state_d = to_t0;
          default:             state_d = S_T6;
        endcase
      end
      S_T6: begin
        case (kind)
          K_LD:    state_d = mem_ready ? S_T7 : S_T6;
          K_ST:    state_d = S_T7;
          default: state_d = to_t0;
        endcase
      end
      S_T7: begin
        if (kind == K_ST) state_d = mem_ready ? to_t0 : S_T7;
        else              state_d = to_t0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Control outputs decoded from the present state and latched instruction class
  always_comb begin
    bus_sel   = '0;
    enable    = '0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    r15_force = 1'b0;
    MD_Read   = 1'b0;
    ReadRAM   = 1'b0;
    WriteRAM  = 1'b0;
    IncPC     = 1'b0;
    alu_op    = '0;
    Run       = 1'b1;
    case (state_q)
      S_T0: begin
        bus_sel[BS_PCOUT] = 1'b1;
        enable[EN_MARIN]  = 1'b1;
        enable[EN_ZIN]    = 1'b1;
        IncPC             = 1'b1;
      end
      S_T1, S_T1W: begin
        bus_sel[BS_ZLOW]  = 1'b1;
        enable[EN_PCIN]   = (state_q == S_T1);
        enable[EN_MDRIN]  = 1'b1;
        ReadRAM           = 1'b1;
        MD_Read           = 1'b1;
      end
      S_T2: begin
        bus_sel[BS_MDROUT] = 1'b1;
        enable[EN_IRIN]    = 1'b1;
      end
      S_T3: begin
        case (kind)
          K_ALU, K_IMM: begin Grb = 1'b1; Rout = 1'b1; enable[EN_YIN] = 1'b1; end
          K_MULDIV:     begin Gra = 1'b1; Rout = 1'b1; enable[EN_YIN] = 1'b1; end
          K_UNARY: begin
            Grb = 1'b1; Rout = 1'b1; enable[EN_ZIN] = 1'b1;
            alu_op = ALU_OPW'(op_q);
          end
          K_LD, K_LDI, K_ST: begin Grb = 1'b1; BAout = 1'b1; enable[EN_YIN] = 1'b1; end
          K_BR:   begin Gra = 1'b1; Rout = 1'b1; enable[EN_CONIN] = 1'b1; end
          K_JR:   begin Gra = 1'b1; Rout = 1'b1; enable[EN_PCIN] = 1'b1; end
          K_JAL:  begin bus_sel[BS_PCOUT] = 1'b1; Rin = 1'b1; r15_force = 1'b1; end
          K_IN:   begin bus_sel[BS_INPORT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          K_OUT:  begin Gra = 1'b1; Rout = 1'b1; enable[EN_OUTPIN] = 1'b1; end
          K_MFHI: begin bus_sel[BS_HIOUT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          K_MFLO: begin bus_sel[BS_LOOUT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (kind)
          K_ALU: begin
            Grc = 1'b1; Rout = 1'b1; enable[EN_ZIN] = 1'b1; alu_op = ALU_OPW'(op_q);
          end
          K_IMM: begin
            bus_sel[BS_COUT] = 1'b1; enable[EN_ZIN] = 1'b1; alu_op = ALU_OPW'(op_q);
          end
          K_MULDIV: begin
            Grb = 1'b1; Rout = 1'b1; enable[EN_ZIN] = 1'b1; alu_op = ALU_OPW'(op_q);
          end
          K_UNARY: begin bus_sel[BS_ZLOW] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          K_LD, K_LDI, K_ST: begin
            bus_sel[BS_COUT] = 1'b1; enable[EN_ZIN] = 1'b1; alu_op = OP_ADD;
          end
          K_BR:  begin bus_sel[BS_PCOUT] = 1'b1; enable[EN_YIN] = 1'b1; end
          K_JAL: begin Gra = 1'b1; Rout = 1'b1; enable[EN_PCIN] = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (kind)
          K_ALU, K_IMM, K_LDI: begin bus_sel[BS_ZLOW] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          K_MULDIV:   begin bus_sel[BS_ZLOW] = 1'b1; enable[EN_LOIN] = 1'b1; end
          K_LD, K_ST: begin bus_sel[BS_ZLOW] = 1'b1; enable[EN_MARIN] = 1'b1; end
          K_BR: begin
            bus_sel[BS_COUT] = 1'b1; enable[EN_ZIN] = 1'b1; alu_op = OP_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (kind)
          K_MULDIV: begin bus_sel[BS_ZHIGH] = 1'b1; enable[EN_HIIN] = 1'b1; end
          K_LD:     begin ReadRAM = 1'b1; MD_Read = 1'b1; enable[EN_MDRIN] = 1'b1; end
          K_ST:     begin Gra = 1'b1; Rout = 1'b1; enable[EN_MDRIN] = 1'b1; end
          K_BR:     begin bus_sel[BS_ZLOW] = 1'b1; enable[EN_PCIN] = CONFFOut; end
          default: ;
        endcase
      end
      S_T7: begin
        case (kind)
          K_LD:    begin bus_sel[BS_MDROUT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          K_ST:    WriteRAM = 1'b1;
          default: ;
        endcase
      end
      S_HALT:  Run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cu_multicycle.sv
// Scoreboard bench for cu_multicycle: the stimulus process expands each
// instruction into its per-cycle control vectors from the micro-step table
// and queues them; the monitor compares one vector per clock at negedge.
module tb_cu_multicycle;

  localparam int MDC = 4;
`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef logic [35:0] vec_t;
  localparam vec_t PCOUT  = 36'h1 << 0,  MDROUT = 36'h1 << 1,  ZHI    = 36'h1 << 2;
  localparam vec_t ZLO    = 36'h1 << 3,  HIOUT  = 36'h1 << 4,  LOOUT  = 36'h1 << 5;
  localparam vec_t INPORT = 36'h1 << 6,  COUT   = 36'h1 << 7;
  localparam vec_t PCIN   = 36'h1 << 8,  IRIN   = 36'h1 << 9,  MARIN  = 36'h1 << 10;
  localparam vec_t MDRIN  = 36'h1 << 11, YIN    = 36'h1 << 12, ZIN    = 36'h1 << 13;
  localparam vec_t HIIN   = 36'h1 << 14, LOIN   = 36'h1 << 15, OUTPIN = 36'h1 << 16;
  localparam vec_t CONIN  = 36'h1 << 17;
  localparam vec_t GRA    = 36'h1 << 18, GRB    = 36'h1 << 19, GRC    = 36'h1 << 20;
  localparam vec_t RIN    = 36'h1 << 21, ROUT   = 36'h1 << 22, BAOUT  = 36'h1 << 23;
  localparam vec_t R15F   = 36'h1 << 24, MDRD   = 36'h1 << 25, RDRAM  = 36'h1 << 26;
  localparam vec_t WRRAM  = 36'h1 << 27, INCPC  = 36'h1 << 28;
  localparam vec_t RUN    = 36'h1 << 34, ILL    = 36'h1 << 35;

  logic        clk, Reset, CONFFOut, mem_ready, Stop;
  logic [31:0] ir;
  logic [7:0]  bus_sel;
  logic [9:0]  enable;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, r15_force, MD_Read, ReadRAM, WriteRAM, IncPC;
  logic [4:0]  alu_op;
  logic        Run, illegal;

  cu_multicycle #(.MULDIV_CYCLES(MDC), .ALU_OPW(5)) dut (
    .clk(clk), .Reset(Reset), .ir(ir), .CONFFOut(CONFFOut), .mem_ready(mem_ready),
    .Stop(Stop), .bus_sel(bus_sel), .enable(enable), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .r15_force(r15_force), .MD_Read(MD_Read),
    .ReadRAM(ReadRAM), .WriteRAM(WriteRAM), .IncPC(IncPC), .alu_op(alu_op),
    .Run(Run), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { vec_t v; string tag; } exp_t;
  exp_t exp_q[$];
  vec_t plan_q[$];
  bit   mr_q[$];
  int   checks = 0, failures = 0;
  exp_t mon_e;
  vec_t act;

  assign act = {illegal, Run, alu_op, IncPC, WriteRAM, ReadRAM, MD_Read, r15_force,
                BAout, Rout, Rin, Grc, Grb, Gra, enable, bus_sel};

  // Monitor: one expected vector per cycle, compared away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (act !== mon_e.v) begin
        failures++;
        $display("FAIL %s act=%h exp=%h", mon_e.tag, act, mon_e.v);
      end
    end
  end

  function automatic vec_t aluf(input logic [4:0] o);
    return vec_t'(o) << 29;
  endfunction

  task automatic step(input vec_t v, input logic mr, input logic st, input string tag);
    @(posedge clk);
    #1;
    mem_ready = mr;
    Stop      = st;
    exp_q.push_back('{v: v, tag: tag});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    Reset = 1'b0;
    Stop  = 1'b0;
    exp_q.push_back('{v: RUN, tag: "reset_low"});
    @(posedge clk);
    #1;
    Reset = 1'b1;
    exp_q.push_back('{v: RUN, tag: "reset_release"});
  endtask

  // plain cycle: memory handshake is a don't-care here, so drive noise
  task automatic pc(input vec_t v);
    plan_q.push_back(v | RUN);
    mr_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // memory-strobe cycle held through n not-ready cycles plus the ready one
  task automatic pw(input vec_t v, input int n);
    for (int k = 0; k <= n; k++) begin
      plan_q.push_back(v | RUN);
      mr_q.push_back(k == n);
    end
  endtask

  task automatic run_instr(input logic [4:0] opc, input int fw, input int mw,
                           input logic cf, input int stop_at);
    bit   halted;
    int   sa;
    vec_t hv;
    plan_q.delete();
    mr_q.delete();
    // fetch and decode
    pc(PCOUT | MARIN | INCPC | ZIN);
    if (fw == 0) pw(ZLO | PCIN | RDRAM | MDRD | MDRIN, 0);
    else begin
      plan_q.push_back(ZLO | PCIN | RDRAM | MDRD | MDRIN | RUN);
      mr_q.push_back(1'b0);
      pw(ZLO | RDRAM | MDRD | MDRIN, fw - 1);
    end
    pc(MDROUT | IRIN);
    pc('0);
    // execute
    if (opc >= 3 && opc <= 11) begin
      pc(GRB | ROUT | YIN); pc(GRC | ROUT | ZIN | aluf(opc)); pc(ZLO | GRA | RIN);
    end else if (opc >= 12 && opc <= 14) begin
      pc(GRB | ROUT | YIN); pc(COUT | ZIN | aluf(opc)); pc(ZLO | GRA | RIN);
    end else if (opc == 15 || opc == 16) begin
      pc(GRA | ROUT | YIN);
      repeat (MDC) pc(GRB | ROUT | ZIN | aluf(opc));
      pc(ZLO | LOIN); pc(ZHI | HIIN);
    end else if (opc == 17 || opc == 18) begin
      pc(GRB | ROUT | ZIN | aluf(opc)); pc(ZLO | GRA | RIN);
    end else if (opc <= 2) begin
      pc(GRB | BAOUT | YIN); pc(COUT | ZIN | aluf(5'd3));
      if (opc == 1) pc(ZLO | GRA | RIN);
      else begin
        pc(ZLO | MARIN);
        if (opc == 0) begin pw(RDRAM | MDRD | MDRIN, mw); pc(MDROUT | GRA | RIN); end
        else begin pc(GRA | ROUT | MDRIN); pw(WRRAM, mw); end
      end
    end else if (opc == 19) begin
      pc(GRA | ROUT | CONIN); pc(PCOUT | YIN); pc(COUT | ZIN | aluf(5'd3));
      pc(ZLO | (cf ? PCIN : vec_t'(0)));
    end else if (opc == 20) pc(GRA | ROUT | PCIN);
    else if (opc == 21) begin pc(PCOUT | RIN | R15F); pc(GRA | ROUT | PCIN); end
    else if (opc == 22) pc(INPORT | GRA | RIN);
    else if (opc == 23) pc(GRA | ROUT | OUTPIN);
    else if (opc == 24) pc(HIOUT | GRA | RIN);
    else if (opc == 25) pc(LOOUT | GRA | RIN);
    // 26 nop, 27 halt and 28..31 add nothing beyond decode

    sa = stop_at;
    if (sa >= plan_q.size()) sa = plan_q.size() - 1;
    halted = (opc == 27) || (TRAP && opc >= 28) || (stop_at >= 0);
    for (int i = 0; i < plan_q.size(); i++) begin
      step(plan_q[i], mr_q[i], (sa >= 0 && i >= sa), $sformatf("op%0d_c%0d", opc, i));
      if (i == 0) begin
        ir       = {opc, 27'($urandom)};
        CONFFOut = cf;
      end
    end
    if (halted) begin
      hv = (TRAP && opc >= 28) ? ILL : vec_t'(0);
      repeat (3) step(hv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $sformatf("halt_op%0d", opc));
      do_reset();
    end
  endtask

  initial begin
    int opc, sa;
    Reset = 1'b0; Stop = 1'b0; mem_ready = 1'b0; CONFFOut = 1'b0; ir = 32'h0;
    do_reset();

    run_instr(5'd3, 0, 0, 1'b0, -1);           // add, no waits
    run_instr(5'd0, 0, 3, 1'b0, -1);           // ld, 3 wait cycles in T6
    run_instr(5'd19, 1, 0, 1'b0, -1);          // branch not taken
    run_instr(5'd19, 0, 0, 1'b1, -1);          // branch taken
    run_instr(5'd16, 0, 0, 1'b0, -1);          // div, held MDC cycles
    run_instr(5'd2, 2, 2, 1'b0, -1);           // st with waits
    run_instr(5'd3, 0, 0, 1'b0, 5);            // Stop raised in T4 of add
    run_instr(5'd30, 0, 0, 1'b0, -1);          // undefined opcode
    run_instr(5'd27, 0, 0, 1'b0, 2);           // halt together with Stop
    run_instr(5'd26, 0, 0, 1'b0, 3);           // Stop at a nop boundary

    // reset while the fetch read is waiting on memory
    step(PCOUT | MARIN | INCPC | ZIN | RUN, 1'b0, 1'b0, "mw_t0");
    step(ZLO | PCIN | RDRAM | MDRD | MDRIN | RUN, 1'b0, 1'b0, "mw_t1");
    @(posedge clk);
    #1;
    Reset = 1'b0;
    exp_q.push_back('{v: RUN, tag: "mw_reset"});
    @(posedge clk);
    #1;
    Reset = 1'b1;
    exp_q.push_back('{v: RUN, tag: "mw_release"});

    for (int n = 0; n < 200; n++) begin
      opc = $urandom_range(0, 31);
      sa  = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 9) : -1;
      run_instr(5'(opc), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), sa);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the stimulus never waits on a DUT event, but guard the run anyway
  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t limit=2000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
